// File: rtl/bsg_link_upstream_credit_tx.sv
// Upstream link transmitter: serialises core words into BEATS channel beats,
// throttled by a credit window that the receiver replenishes with tokens.
module bsg_link_upstream_credit_tx #(
    parameter int unsigned CH_NUM       = 2,
    parameter int unsigned CH_W         = 8,
    parameter int unsigned BEATS        = 4,
    parameter int unsigned CNT_W        = 7,
    parameter int unsigned MAX_CREDITS  = 32,
    parameter int unsigned TOKEN_DECIM  = 8,
    parameter int unsigned TOKEN_TOGGLE = 0,
    localparam int unsigned DATA_W      = CH_NUM * CH_W * BEATS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      core_data_i,
    input  logic                   core_valid_i,
    output logic                   core_ready_o,
    input  logic                   io_token_i,
    output logic                   io_valid_o,
    output logic [CH_NUM*CH_W-1:0] io_data_o,
    output logic [CNT_W-1:0]       outstanding_o,
    output logic                   token_err_o
);

    localparam int unsigned SLICE_W = CH_NUM * CH_W;
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CREDITS);
    localparam logic [CNT_W-1:0]  DECIM     = CNT_W'(TOKEN_DECIM);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    sent_q, sent_d;
    logic [CNT_W-1:0]    finish_q, finish_d;
    logic                tok_q;
    logic                err_q, err_d;
    logic                io_valid_q, io_valid_d;
    logic [SLICE_W-1:0]  io_data_q, io_data_d;

    logic [CNT_W-1:0]    outstanding;
    logic                avail;
    logic                accept;
    logic                tok_evt;
    logic                tok_ok;

    // Credit and handshake logic, all from registered state.
    assign outstanding  = sent_q - finish_q;
    assign avail        = (outstanding < MAX_C);
    assign core_ready_o = avail && ((state_q == IDLE) || (beat_q == LAST_BEAT));
    assign accept       = core_valid_i && core_ready_o;

    assign tok_evt  = (TOKEN_TOGGLE != 0) ? (io_token_i ^ tok_q) : io_token_i;
    assign tok_ok   = tok_evt && (outstanding >= DECIM);
    assign sent_d   = sent_q + CNT_W'(accept);
    assign finish_d = tok_ok ? (finish_q + DECIM) : finish_q;
    assign err_d    = err_q | (tok_evt & ~tok_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            word_q     <= '0;
            sent_q     <= '0;
            finish_q   <= '0;
            tok_q      <= 1'b0;
            err_q      <= 1'b0;
            io_valid_q <= 1'b0;
            io_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            sent_q     <= sent_d;
            finish_q   <= finish_d;
            tok_q      <= io_token_i;
            err_q      <= err_d;
            io_valid_q <= io_valid_d;
            io_data_q  <= io_data_d;
        end
    end

    // The word register shifts down one beat per cycle, so the next beat to
    // present is always its low slice; beat 0 comes straight from the input.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        word_d  = word_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    beat_d  = '0;
                    word_d  = core_data_i >> SLICE_W;
                end
            end
            SEND: begin
                if (beat_q != LAST_BEAT) begin
                    beat_d = beat_q + 1'b1;
                    word_d = word_q >> SLICE_W;
                end else if (accept) begin
                    beat_d = '0;
                    word_d = core_data_i >> SLICE_W;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io_valid_d = (state_d == SEND);
        io_data_d  = io_data_q;
        if (state_d == SEND) begin
            io_data_d = accept ? core_data_i[SLICE_W-1:0] : word_q[SLICE_W-1:0];
        end
    end

    assign io_valid_o    = io_valid_q;
    assign io_data_o     = io_data_q;
    assign outstanding_o = outstanding;
    assign token_err_o   = err_q;

endmodule

// File: tb/tb_bsg_link_upstream_credit_tx.sv
// Self-checking bench: vector table, directed credit/token sequences and a
// randomized run against a queue-based reference model.
module tb_bsg_link_upstream_credit_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, core_valid, tok, ready, io_valid, err;
    logic [63:0] core_data;
    logic [15:0] io_data;
    logic [6:0]  outst;

    logic        t_rst, t_valid, t_tok, t_ready, t_io_valid, t_err;
    logic [63:0] t_data;
    logic [15:0] t_io_data;
    logic [6:0]  t_outst;

    bsg_link_upstream_credit_tx #(.CH_NUM(2), .CH_W(8), .BEATS(4), .CNT_W(7),
        .MAX_CREDITS(32), .TOKEN_DECIM(8), .TOKEN_TOGGLE(0)) u_dut (
        .clk(clk), .rst(rst), .core_data_i(core_data), .core_valid_i(core_valid),
        .core_ready_o(ready), .io_token_i(tok), .io_valid_o(io_valid),
        .io_data_o(io_data), .outstanding_o(outst), .token_err_o(err));

    bsg_link_upstream_credit_tx #(.CH_NUM(2), .CH_W(8), .BEATS(4), .CNT_W(7),
        .MAX_CREDITS(32), .TOKEN_DECIM(8), .TOKEN_TOGGLE(1)) u_tog (
        .clk(clk), .rst(t_rst), .core_data_i(t_data), .core_valid_i(t_valid),
        .core_ready_o(t_ready), .io_token_i(t_tok), .io_valid_o(t_io_valid),
        .io_data_o(t_io_data), .outstanding_o(t_outst), .token_err_o(t_err));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: beats still to be shown, plus unbounded word counts.
    logic [15:0] m_pend[$];
    int          m_sent, m_fin;
    bit          m_err;
    logic        m_valid;
    logic [15:0] m_data;

    task automatic m_reset();
        m_pend.delete();
        m_sent = 0; m_fin = 0; m_err = 0; m_valid = 0; m_data = '0;
    endtask

    function automatic bit m_ready();
        return ((m_sent - m_fin) < 32) && (m_pend.size() == 0);
    endfunction

    task automatic m_edge(input bit v, input logic [63:0] d, input bit t);
        int o;
        bit acc;
        o   = m_sent - m_fin;
        acc = v && m_ready();
        if (t) begin
            if (o >= 8) m_fin += 8;
            else m_err = 1;
        end
        if (acc) begin
            m_sent++;
            for (int b = 0; b < 4; b++) m_pend.push_back(d[b*16 +: 16]);
        end
        if (m_pend.size() > 0) begin
            m_valid = 1;
            m_data  = m_pend.pop_front();
        end else begin
            m_valid = 0;
        end
    endtask

    typedef struct {
        logic        valid;
        logic        token;
        logic [63:0] data;
        logic        e_ready;
        logic        e_valid;
        logic [15:0] e_data;
        logic [6:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int acc, acc2, vcnt, first, last, n;
        bit v, t;
        logic [63:0] d;

        vecs[0] = '{1, 0, 64'h0123_4567_89AB_CDEF, 0, 1, 16'hCDEF, 7'd1, 0};
        vecs[1] = '{0, 0, 64'h0,                   0, 1, 16'h89AB, 7'd1, 0};
        vecs[2] = '{0, 0, 64'h0,                   0, 1, 16'h4567, 7'd1, 0};
        vecs[3] = '{0, 0, 64'h0,                   1, 1, 16'h0123, 7'd1, 0};
        vecs[4] = '{0, 0, 64'h0,                   1, 0, 16'h0123, 7'd1, 0};
        vecs[5] = '{0, 1, 64'h0,                   1, 0, 16'h0123, 7'd1, 1};
        vecs[6] = '{0, 0, 64'h0,                   1, 0, 16'h0123, 7'd1, 1};

        rst = 1; core_valid = 0; core_data = '0; tok = 0;
        t_rst = 1; t_valid = 0; t_data = '0; t_tok = 0;
        tick(); tick();
        chk("reset io_valid", io_valid, 0);
        chk("reset io_data", io_data, 0);
        chk("reset outstanding", outst, 0);
        chk("reset token_err", err, 0);
        chk("reset ready", ready, 1);
        rst = 0;

        for (int i = 0; i < 7; i++) begin
            core_valid = vecs[i].valid;
            core_data  = vecs[i].data;
            tok        = vecs[i].token;
            tick();
            chk($sformatf("vec%0d ready", i), ready, vecs[i].e_ready);
            chk($sformatf("vec%0d io_valid", i), io_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d io_data", i), io_data, vecs[i].e_data);
            chk($sformatf("vec%0d outstanding", i), outst, vecs[i].e_out);
            chk($sformatf("vec%0d token_err", i), err, vecs[i].e_err);
        end
        core_valid = 0; tok = 0;

        // Fill the credit window with valid held high.
        rst = 1; tick(); rst = 0;
        core_valid = 1; acc = 0;
        for (int c = 0; c < 300; c++) begin
            core_data = {$urandom, $urandom};
            if (ready) acc++;
            tick();
        end
        chk("fill accepted", acc, 32);
        chk("fill ready", ready, 0);
        chk("fill outstanding", outst, 32);

        // One token frees 8 credits; the next 8 words go out gaplessly.
        tok = 1; tick(); tok = 0;
        chk("token outstanding", outst, 24);
        acc2 = 0; vcnt = 0; first = -1; last = -1;
        for (int c = 0; c < 80; c++) begin
            core_data = {$urandom, $urandom};
            if (ready) acc2++;
            tick();
            if (io_valid) begin
                vcnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        core_valid = 0;
        chk("refill accepted", acc2, 8);
        chk("refill beats", vcnt, 32);
        chk("refill gapless", last - first + 1, 32);
        chk("refill outstanding", outst, 32);

        // Token with only 3 words outstanding is an error and retires nothing.
        rst = 1; tick(); rst = 0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (n < 3) begin
                core_valid = 1;
                core_data  = {$urandom, $urandom};
                if (ready) n++;
            end else begin
                core_valid = 0;
            end
            tick();
        end
        chk("err pre outstanding", outst, 3);
        tok = 1; tick(); tok = 0;
        chk("err flag", err, 1);
        chk("err outstanding", outst, 3);
        repeat (5) tick();
        chk("err sticky", err, 1);
        chk("err outstanding hold", outst, 3);

        // Randomized run past the counter wrap.
        rst = 1; tick(); rst = 0;
        m_reset();
        for (int c = 0; c < 6000 && m_sent < 220; c++) begin
            chk($sformatf("rand c%0d ready", c), ready, m_ready());
            chk($sformatf("rand c%0d io_valid", c), io_valid, m_valid);
            chk($sformatf("rand c%0d io_data", c), io_data, m_data);
            chk($sformatf("rand c%0d outstanding", c), outst, 64'(m_sent - m_fin));
            chk($sformatf("rand c%0d token_err", c), err, m_err);
            v = ($urandom % 4) != 0;
            d = {$urandom, $urandom};
            t = ((m_sent - m_fin) >= 8) && (($urandom % 2) == 0);
            core_valid = v; core_data = d; tok = t;
            tick();
            m_edge(v, d, t);
        end
        core_valid = 0; tok = 0;
        chk("rand final outstanding", outst, 64'(m_sent - m_fin));
        chk("rand final token_err", err, 0);

        // Toggle-mode tokens and reset mid-word.
        t_rst = 1; tick(); t_rst = 0;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (n < 20) begin
                t_valid = 1;
                t_data  = {$urandom, $urandom};
                if (t_ready) n++;
            end else begin
                t_valid = 0;
            end
            tick();
        end
        chk("tog pre outstanding", t_outst, 20);
        t_tok = 1; tick();
        chk("tog rise outstanding", t_outst, 12);
        t_tok = 0; tick(); tick();
        chk("tog fall outstanding", t_outst, 4);
        chk("tog token_err", t_err, 0);

        t_valid = 1; t_data = 64'h0123_4567_89AB_CDEF;
        tick();
        t_valid = 0;
        chk("tog beat0 valid", t_io_valid, 1);
        chk("tog beat0 data", t_io_data, 16'hCDEF);
        tick(); tick();
        chk("tog beat2 data", t_io_data, 16'h4567);
        t_rst = 1; tick();
        chk("midrst io_valid", t_io_valid, 0);
        chk("midrst io_data", t_io_data, 0);
        chk("midrst outstanding", t_outst, 0);
        chk("midrst token_err", t_err, 0);
        t_rst = 0; tick();
        chk("midrst io_valid after", t_io_valid, 0);
        chk("midrst ready", t_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
